// File: rtl/run_dispatch_fifo_pkg.sv
// Shared state encoding and default parameters for the run dispatch FIFO.
package run_dispatch_pkg;

    localparam int DEF_DATA_W       = 32;
    localparam int DEF_DEPTH_LOG2   = 4;
    localparam int DEF_BUSY_TIMEOUT = 16;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT_BUSY,
        ST_WAIT_DONE
    } disp_state_t;

endpackage

// File: rtl/run_dispatch_fifo_if.sv
// Push side and downstream run-method handshake of the run dispatch FIFO.
interface run_dispatch_fifo_if
    import run_dispatch_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
);

    logic                  i_wr_en;
    logic [DATA_W-1:0]     i_wr_data;
    logic                  o_full;
    logic [DEPTH_LOG2:0]   o_count;
    logic                  o_run_req;
    logic [DATA_W-1:0]     o_run_arg;
    logic                  i_run_busy;

    modport master (
        output i_wr_en, i_wr_data, i_run_busy,
        input  o_full, o_count, o_run_req, o_run_arg
    );

    modport slave (
        input  i_wr_en, i_wr_data, i_run_busy,
        output o_full, o_count, o_run_req, o_run_arg
    );

endinterface

// File: rtl/run_dispatch_fifo_sync_fifo.sv
// Single-clock FIFO with wrapping pointers and a separate occupancy counter.
module sync_fifo
    import run_dispatch_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int DEPTH_LOG2 = DEF_DEPTH_LOG2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                ce,
    input  logic                wr_en,
    input  logic [DATA_W-1:0]   wr_data,
    input  logic                rd_en,
    output logic [DATA_W-1:0]   rd_data,
    output logic                full,
    output logic                empty,
    output logic [DEPTH_LOG2:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [DATA_W-1:0]     mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic                  push;
    logic                  pop;

    // A push while full is dropped even if a pop frees a slot this cycle.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push    = wr_en && !full;
    assign pop     = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (ce && push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (ce) begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/run_dispatch_fifo.sv
// Queues argument words and hands them one at a time to a downstream
// run-style method, watching its busy line for start and completion.
module run_dispatch_fifo
    import run_dispatch_pkg::*;
#(
    parameter int DATA_W       = DEF_DATA_W,
    parameter int DEPTH_LOG2   = DEF_DEPTH_LOG2,
    parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ce,
    run_dispatch_fifo_if.slave bus,
    output logic               o_idle,
    output logic [31:0]        o_done_cnt,
    output logic               o_overflow,
    output logic               o_timeout
);

    localparam int TIMER_W = $clog2(BUSY_TIMEOUT + 1);
    localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(BUSY_TIMEOUT - 1);

    disp_state_t         state;
    disp_state_t         next_state;
    logic [TIMER_W-1:0]  timer;
    logic [DATA_W-1:0]   run_arg;
    logic [DATA_W-1:0]   head;
    logic [DEPTH_LOG2:0] fifo_count;
    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    logic                timeout_hit;
    logic                run_done;

    sync_fifo #(
        .DATA_W     (DATA_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .ce      (ce),
        .wr_en   (bus.i_wr_en),
        .wr_data (bus.i_wr_data),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else if (ce) begin
            state <= next_state;
        end
    end

    // Busy wins over the timeout when both land on the same cycle.
    always_comb begin
        next_state  = state;
        pop         = 1'b0;
        timeout_hit = 1'b0;
        run_done    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    next_state = ST_REQ;
                end
            end
            ST_REQ: begin
                next_state = ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
                if (bus.i_run_busy) begin
                    next_state = ST_WAIT_DONE;
                end else if (timer == TIMER_LAST) begin
                    timeout_hit = 1'b1;
                    next_state  = ST_IDLE;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.i_run_busy) begin
                    run_done   = 1'b1;
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            timer      <= '0;
            run_arg    <= '0;
            o_done_cnt <= '0;
            o_overflow <= 1'b0;
            o_timeout  <= 1'b0;
        end else if (ce) begin
            if (state == ST_WAIT_BUSY && next_state == ST_WAIT_BUSY) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
            if (pop) begin
                run_arg <= head;
            end
            if (run_done) begin
                o_done_cnt <= o_done_cnt + 32'd1;
            end
            if (timeout_hit) begin
                o_timeout <= 1'b1;
            end
            if (bus.i_wr_en && fifo_full) begin
                o_overflow <= 1'b1;
            end
        end
    end

    assign bus.o_full    = fifo_full;
    assign bus.o_count   = fifo_count;
    assign bus.o_run_req = (state == ST_REQ);
    assign bus.o_run_arg = run_arg;
    assign o_idle        = (state == ST_IDLE) && fifo_empty;

endmodule
